// File: rtl/cr_xp10_decomp_be_ob_arb.sv
// XP10 decompressor back-end outbound arbiter: LZ data FIFO plus frame-atomic merge with the
// pass-through FIFO into one TLV stream. Optional per-source frame counters: XP10_OB_STATS_EN.
package cr_xp10_decomp_be_ob_arb_pkg;
  typedef struct packed {
    logic        sot;
    logic        eot;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } tlvp_if_bus_t;
endpackage

module cr_xp10_decomp_be_ob_arb
  import cr_xp10_decomp_be_ob_arb_pkg::*;
#(
  parameter int LZ_DEPTH        = 16,
  parameter int LZ_AFULL_MARGIN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         lz_data_wr,
  input  tlvp_if_bus_t lz_data_tlv,
  output logic         lz_data_full,
  output logic         lz_data_afull,
  input  logic         pt_ob_empty,
  input  tlvp_if_bus_t pt_ob_tlv,
  output logic         pt_ob_rd,
  output logic         ob_valid,
  output tlvp_if_bus_t ob_tlv,
  input  logic         ob_ready,
  output logic         ob_seq_err,
  output logic         lz_ovfl_err
`ifdef XP10_OB_STATS_EN
  ,
  output logic [31:0]  stat_pt_frames,
  output logic [31:0]  stat_lz_frames
`endif
);

  localparam int AW = $clog2(LZ_DEPTH);
  localparam int UW = AW + 1;
  localparam logic [UW-1:0] DEPTH_U = UW'(LZ_DEPTH);
  localparam logic [UW-1:0] AFULL_U = UW'(LZ_DEPTH - LZ_AFULL_MARGIN);

  typedef enum logic [1:0] {ST_IDLE, ST_PT, ST_LZ} state_e;

  // ---------------- LZ data FIFO ----------------
  tlvp_if_bus_t  lz_mem [LZ_DEPTH];
  tlvp_if_bus_t  lz_head_q;
  logic [AW-1:0] lz_wr_ptr_q;
  logic [AW-1:0] lz_rd_ptr_q;
  logic [AW-1:0] lz_rd_ptr_d;
  logic [UW-1:0] lz_used_q;
  logic [UW-1:0] lz_used_d;
  logic          lz_push;
  logic          lz_pop;
  logic          lz_nonempty;

  assign lz_data_full  = (lz_used_q == DEPTH_U);
  assign lz_data_afull = (lz_used_q >= AFULL_U);
  assign lz_nonempty   = (lz_used_q != '0);
  assign lz_push       = lz_data_wr && !lz_data_full;

  always_comb begin
    lz_rd_ptr_d = lz_rd_ptr_q + AW'(lz_pop);
    lz_used_d   = lz_used_q + UW'(lz_push) - UW'(lz_pop);
  end

  always_ff @(posedge clk) begin
    if (lz_push) begin
      lz_mem[lz_wr_ptr_q] <= lz_data_tlv;
    end
  end

  // Registered read at the next read pointer keeps the head show-ahead; bypass covers a write
  // landing on the entry that becomes the head in the same cycle.
  always_ff @(posedge clk) begin
    if (lz_push && (lz_wr_ptr_q == lz_rd_ptr_d)) begin
      lz_head_q <= lz_data_tlv;
    end else begin
      lz_head_q <= lz_mem[lz_rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lz_wr_ptr_q <= '0;
      lz_rd_ptr_q <= '0;
      lz_used_q   <= '0;
    end else begin
      if (lz_push) begin
        lz_wr_ptr_q <= lz_wr_ptr_q + AW'(1);
      end
      lz_rd_ptr_q <= lz_rd_ptr_d;
      lz_used_q   <= lz_used_d;
    end
  end

  // ---------------- Arbiter FSM and output register ----------------
  state_e       state_q;
  logic         rr_lz_q;
  logic         first_q;
  logic         ob_valid_q;
  tlvp_if_bus_t ob_tlv_q;
  logic         seq_err_q;
  logic         ovfl_err_q;
  logic         load_ok;
  logic         pt_head;
  logic         pt_pop;
  logic         any_pop;
  tlvp_if_bus_t pop_tlv;

  assign load_ok  = !ob_valid_q || ob_ready;
  assign pt_head  = !pt_ob_empty;
  assign pt_pop   = (state_q == ST_PT) && pt_head && load_ok && !rst;
  assign lz_pop   = (state_q == ST_LZ) && lz_nonempty && load_ok && !rst;
  assign any_pop  = pt_pop || lz_pop;
  assign pop_tlv  = (state_q == ST_LZ) ? lz_head_q : pt_ob_tlv;
  assign pt_ob_rd = pt_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_lz_q    <= 1'b0;
      first_q    <= 1'b1;
      ob_valid_q <= 1'b0;
      ob_tlv_q   <= '0;
      seq_err_q  <= 1'b0;
      ovfl_err_q <= 1'b0;
    end else begin
      if (lz_data_wr && lz_data_full) begin
        ovfl_err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          first_q <= 1'b1;
          if (pt_head && (!lz_nonempty || !rr_lz_q)) begin
            state_q <= ST_PT;
          end else if (lz_nonempty) begin
            state_q <= ST_LZ;
          end
        end
        ST_PT: begin
          if (pt_pop && pop_tlv.eot) begin
            state_q <= ST_IDLE;
            rr_lz_q <= 1'b1;
          end
        end
        ST_LZ: begin
          if (lz_pop && pop_tlv.eot) begin
            state_q <= ST_IDLE;
            rr_lz_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // First beat of a grant must carry sot, every later beat must not.
      if (any_pop) begin
        first_q    <= 1'b0;
        ob_tlv_q   <= pop_tlv;
        ob_valid_q <= 1'b1;
        if (first_q != pop_tlv.sot) begin
          seq_err_q <= 1'b1;
        end
      end else if (ob_valid_q && ob_ready) begin
        ob_valid_q <= 1'b0;
      end
    end
  end

  assign ob_valid    = ob_valid_q;
  assign ob_tlv      = ob_tlv_q;
  assign ob_seq_err  = seq_err_q;
  assign lz_ovfl_err = ovfl_err_q;

`ifdef XP10_OB_STATS_EN
  logic        src_lz_q;
  logic [31:0] stat_pt_q;
  logic [31:0] stat_lz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      src_lz_q  <= 1'b0;
      stat_pt_q <= '0;
      stat_lz_q <= '0;
    end else begin
      if (any_pop) begin
        src_lz_q <= lz_pop;
      end
      if (ob_valid_q && ob_ready && ob_tlv_q.eot) begin
        if (src_lz_q) begin
          stat_lz_q <= stat_lz_q + 32'd1;
        end else begin
          stat_pt_q <= stat_pt_q + 32'd1;
        end
      end
    end
  end

  assign stat_pt_frames = stat_pt_q;
  assign stat_lz_frames = stat_lz_q;
`endif

endmodule

// File: tb/tb_cr_xp10_decomp_be_ob_arb.sv
// Directed bench for cr_xp10_decomp_be_ob_arb: models the pass-through FIFO, records every
// accepted output beat with its cycle, and compares against hand-computed tables.
module tb_cr_xp10_decomp_be_ob_arb;
  import cr_xp10_decomp_be_ob_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         lz_data_wr;
  tlvp_if_bus_t lz_data_tlv;
  logic         lz_data_full;
  logic         lz_data_afull;
  logic         pt_ob_empty;
  tlvp_if_bus_t pt_ob_tlv;
  logic         pt_ob_rd;
  logic         ob_valid;
  tlvp_if_bus_t ob_tlv;
  logic         ob_ready;
  logic         ob_seq_err;
  logic         lz_ovfl_err;
`ifdef XP10_OB_STATS_EN
  logic [31:0]  stat_pt_frames;
  logic [31:0]  stat_lz_frames;
`endif

  always #5 clk = ~clk;

  cr_xp10_decomp_be_ob_arb #(.LZ_DEPTH(16), .LZ_AFULL_MARGIN(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .lz_data_wr    (lz_data_wr),
    .lz_data_tlv   (lz_data_tlv),
    .lz_data_full  (lz_data_full),
    .lz_data_afull (lz_data_afull),
    .pt_ob_empty   (pt_ob_empty),
    .pt_ob_tlv     (pt_ob_tlv),
    .pt_ob_rd      (pt_ob_rd),
    .ob_valid      (ob_valid),
    .ob_tlv        (ob_tlv),
    .ob_ready      (ob_ready),
    .ob_seq_err    (ob_seq_err),
    .lz_ovfl_err   (lz_ovfl_err)
`ifdef XP10_OB_STATS_EN
    ,
    .stat_pt_frames(stat_pt_frames),
    .stat_lz_frames(stat_lz_frames)
`endif
  );

  // Pass-through FIFO model: show-ahead head, popped on pt_ob_rd.
  tlvp_if_bus_t pt_mem [64];
  int           pt_wr = 0;
  int           pt_rd = 0;
  logic         pt_flush = 1'b0;
  int           cyc = 0;

  assign pt_ob_empty = (pt_rd == pt_wr);
  assign pt_ob_tlv   = pt_mem[pt_rd[5:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pt_flush) pt_rd <= pt_wr;
    else if (pt_ob_rd) pt_rd <= pt_rd + 1;
  end

  // Output monitor: a beat is accepted at the next edge when valid && ready.
  tlvp_if_bus_t got_q [$];
  int           got_cyc [$];
  always @(negedge clk) begin
    if (!rst && ob_valid && ob_ready) begin
      got_q.push_back(ob_tlv);
      got_cyc.push_back(cyc);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  function automatic tlvp_if_bus_t mk(logic s, logic e, logic [15:0] tag);
    tlvp_if_bus_t t;
    t.sot   = s;
    t.eot   = e;
    t.tuser = tag[7:0] ^ 8'h5A;
    t.tdata = {tag, 32'hC0DE_0000, tag};
    return t;
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end else $display("ok   %s = %0b", name, act);
  endtask

  task automatic chki(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else $display("ok   %s = %0d", name, act);
  endtask

  task automatic chkt(string name, tlvp_if_bus_t act, tlvp_if_bus_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else $display("ok   %s = %h", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_pt(tlvp_if_bus_t t);
    pt_mem[pt_wr[5:0]] = t;
    pt_wr++;
  endtask

  task automatic push_lz(tlvp_if_bus_t t);
    lz_data_wr  = 1'b1;
    lz_data_tlv = t;
    tick();
    lz_data_wr  = 1'b0;
  endtask

  task automatic wait_out(int n, string name);
    int b = 0;
    while (got_q.size() < n && b < 300) begin
      tick();
      b++;
    end
    n_tests++;
    if (got_q.size() < n) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d beats expected %0d", name, got_q.size(), n);
    end else $display("ok   %s reached %0d beats", name, n);
  endtask

  typedef struct {
    logic [15:0] tag;
    logic        sot;
    logic        eot;
    int          dcyc;
  } out_vec_t;

  typedef struct {
    int   n_push;
    logic exp_full;
    logic exp_afull;
    logic exp_ovfl;
  } lvl_vec_t;

  out_vec_t t2_tab [5];
  lvl_vec_t lvl_tab [5];

  initial begin
    int base;
    int g;
    int lz_idx;

    // Scenario 2 order: PT0..PT2, one bubble, LZ0..LZ1; offsets from the cycle both heads show.
    t2_tab[0] = '{16'h0100, 1'b1, 1'b0, 2};
    t2_tab[1] = '{16'h0101, 1'b0, 1'b0, 3};
    t2_tab[2] = '{16'h0102, 1'b0, 1'b1, 4};
    t2_tab[3] = '{16'h0200, 1'b1, 1'b0, 6};
    t2_tab[4] = '{16'h0201, 1'b0, 1'b1, 7};
    // Cumulative LZ fill: afull at 12, full at 16, 17th push dropped.
    lvl_tab[0] = '{11, 1'b0, 1'b0, 1'b0};
    lvl_tab[1] = '{1,  1'b0, 1'b1, 1'b0};
    lvl_tab[2] = '{3,  1'b0, 1'b1, 1'b0};
    lvl_tab[3] = '{1,  1'b1, 1'b1, 1'b0};
    lvl_tab[4] = '{1,  1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    lz_data_wr = 1'b0;
    lz_data_tlv = '0;
    ob_ready = 1'b1;
    repeat (3) tick();
    chk1("reset ob_valid", ob_valid, 1'b0);
    chk1("reset full", lz_data_full, 1'b0);
    chk1("reset afull", lz_data_afull, 1'b0);
    chk1("reset seq_err", ob_seq_err, 1'b0);
    chk1("reset ovfl_err", lz_ovfl_err, 1'b0);
    chk1("reset pt_ob_rd", pt_ob_rd, 1'b0);
    rst = 1'b0;
    repeat (2) tick();

    // ---- both heads present, rr_ptr=PT ----
    base = got_q.size();
    push_lz(mk(1'b1, 1'b0, 16'h0200));
    lz_data_wr  = 1'b1;
    lz_data_tlv = mk(1'b0, 1'b1, 16'h0201);
    add_pt(mk(1'b1, 1'b0, 16'h0100));
    add_pt(mk(1'b0, 1'b0, 16'h0101));
    add_pt(mk(1'b0, 1'b1, 16'h0102));
    g = cyc;
    tick();
    lz_data_wr = 1'b0;
    wait_out(base + 5, "t2 beats");
    repeat (3) tick();
    chki("t2 beat count", got_q.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      chkt($sformatf("t2 beat%0d", i), got_q[base + i],
           mk(t2_tab[i].sot, t2_tab[i].eot, t2_tab[i].tag));
      chki($sformatf("t2 beat%0d cycle", i), got_cyc[base + i] - g, t2_tab[i].dcyc);
    end

    // ---- downstream stall mid-frame ----
    base = got_q.size();
    for (int i = 0; i < 6; i++) add_pt(mk(i == 0, i == 5, 16'(16'h0300 + i)));
    repeat (3) tick();
    ob_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chkt($sformatf("t3 hold tlv c%0d", i), ob_tlv, mk(1'b0, 1'b0, 16'h0301));
      chk1($sformatf("t3 hold valid c%0d", i), ob_valid, 1'b1);
      chk1($sformatf("t3 no pop c%0d", i), pt_ob_rd, 1'b0);
      tick();
    end
    ob_ready = 1'b1;
    wait_out(base + 6, "t3 beats");
    repeat (3) tick();
    chki("t3 beat count", got_q.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      chkt($sformatf("t3 beat%0d", i), got_q[base + i], mk(i == 0, i == 5, 16'(16'h0300 + i)));
    end
    for (int i = 2; i < 6; i++) begin
      chki($sformatf("t3 beat%0d spacing", i), got_cyc[base + i] - got_cyc[base + i - 1], 1);
    end

    // ---- LZ FIFO levels while PT frame holds the grant ----
    base = got_q.size();
    add_pt(mk(1'b1, 1'b0, 16'h0400));
    wait_out(base + 1, "t4 pt sot");
    lz_idx = 0;
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < lvl_tab[r].n_push; j++) begin
        push_lz(mk(lz_idx == 0, lz_idx == 15, (lz_idx < 16) ? 16'(16'h0500 + lz_idx) : 16'hEEEE));
        lz_idx++;
      end
      chk1($sformatf("t4 full after %0d", lz_idx), lz_data_full, lvl_tab[r].exp_full);
      chk1($sformatf("t4 afull after %0d", lz_idx), lz_data_afull, lvl_tab[r].exp_afull);
      chk1($sformatf("t4 ovfl after %0d", lz_idx), lz_ovfl_err, lvl_tab[r].exp_ovfl);
    end
    // End the PT frame; two cycles later the LZ FIFO pops its first beat while a push arrives.
    add_pt(mk(1'b0, 1'b1, 16'h0401));
    tick();
    tick();
    push_lz(mk(1'b1, 1'b1, 16'hDDDD));
    chk1("t4 full after push+pop", lz_data_full, 1'b0);
    chk1("t4 afull after push+pop", lz_data_afull, 1'b1);
    chk1("t4 ovfl sticky", lz_ovfl_err, 1'b1);
    wait_out(base + 18, "t4 drain");
    repeat (3) tick();
    chki("t4 beat count", got_q.size() - base, 18);
    chkt("t4 pt eot", got_q[base + 1], mk(1'b0, 1'b1, 16'h0401));
    for (int i = 0; i < 16; i++) begin
      chkt($sformatf("t4 lz beat%0d", i), got_q[base + 2 + i], mk(i == 0, i == 15, 16'(16'h0500 + i)));
    end
`ifdef XP10_OB_STATS_EN
    chki("stat_pt_frames", int'(stat_pt_frames), 3);
    chki("stat_lz_frames", int'(stat_lz_frames), 2);
`endif

    // ---- framing violation on an LZ frame ----
    chk1("t5 seq_err before", ob_seq_err, 1'b0);
    base = got_q.size();
    push_lz(mk(1'b1, 1'b0, 16'h0600));
    push_lz(mk(1'b1, 1'b0, 16'h0601));
    push_lz(mk(1'b0, 1'b1, 16'h0602));
    wait_out(base + 3, "t5 beats");
    repeat (3) tick();
    chk1("t5 seq_err set", ob_seq_err, 1'b1);
    chki("t5 beat count", got_q.size() - base, 3);
    chkt("t5 beat1 forwarded", got_q[base + 1], mk(1'b1, 1'b0, 16'h0601));
    chkt("t5 beat2 forwarded", got_q[base + 2], mk(1'b0, 1'b1, 16'h0602));
    repeat (4) tick();
    chk1("t5 seq_err sticky", ob_seq_err, 1'b1);

    // ---- reset mid-frame with a held output beat ----
    ob_ready = 1'b0;
    add_pt(mk(1'b1, 1'b0, 16'h0700));
    add_pt(mk(1'b0, 1'b0, 16'h0701));
    add_pt(mk(1'b0, 1'b1, 16'h0702));
    repeat (4) tick();
    chk1("t1 valid before reset", ob_valid, 1'b1);
    rst = 1'b1;
    pt_flush = 1'b1;
    tick();
    chk1("t1 ob_valid", ob_valid, 1'b0);
    chk1("t1 full", lz_data_full, 1'b0);
    chk1("t1 seq_err cleared", ob_seq_err, 1'b0);
    chk1("t1 ovfl cleared", lz_ovfl_err, 1'b0);
    chkt("t1 ob_tlv cleared", ob_tlv, '0);
    tick();
    rst = 1'b0;
    pt_flush = 1'b0;
    ob_ready = 1'b1;
    base = got_q.size();
    add_pt(mk(1'b1, 1'b0, 16'h0800));
    add_pt(mk(1'b0, 1'b1, 16'h0801));
    g = cyc;
    #1;
    chk1("t1 idle grant no pop", pt_ob_rd, 1'b0);
    wait_out(base + 2, "t1 beats");
    repeat (2) tick();
    chki("t1 beat count", got_q.size() - base, 2);
    chkt("t1 first beat sot", got_q[base], mk(1'b1, 1'b0, 16'h0800));
    chki("t1 first beat latency", got_cyc[base] - g, 2);
    chkt("t1 second beat", got_q[base + 1], mk(1'b0, 1'b1, 16'h0801));
    chk1("t1 seq_err after frame", ob_seq_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
